// File: rtl/ericsmi_bad_sync_pkg.sv
// ericsmi_bad_sync_pkg
// Shared definitions for the bad-synchronizer metastability demonstrator:
// read-select encodings, fixed read-back constants, status-byte bit positions
// and a helper that assembles the status byte.
// Optional build macro used by the design: BADSYNC_SNAPSHOT_EN (see top file).
package ericsmi_bad_sync_pkg;

    typedef enum logic [2:0] {
        SEL_MIS_LO  = 3'd0,
        SEL_MIS_HI  = 3'd1,
        SEL_BAD_LO  = 3'd2,
        SEL_BAD_HI  = 3'd3,
        SEL_GOOD_LO = 3'd4,
        SEL_GOOD_HI = 3'd5,
        SEL_STATUS  = 3'd6,
        SEL_ID      = 3'd7
    } sel_e;

    localparam logic [7:0] ID_BYTE    = 8'hA5;
    localparam logic [7:0] UIO_OE_VAL = 8'h03;

    // Status byte layout: {3'b0, sat_good, sat_bad, sat_mis, sync_out, q_bad_d}
    localparam int ST_BAD      = 0;
    localparam int ST_GOOD     = 1;
    localparam int ST_SAT_MIS  = 2;
    localparam int ST_SAT_BAD  = 3;
    localparam int ST_SAT_GOOD = 4;

    function automatic logic [7:0] pack_status(
        input logic sat_good,
        input logic sat_bad,
        input logic sat_mis,
        input logic good_bit,
        input logic bad_bit
    );
        logic [7:0] s;
        s              = '0;
        s[ST_BAD]      = bad_bit;
        s[ST_GOOD]     = good_bit;
        s[ST_SAT_MIS]  = sat_mis;
        s[ST_SAT_BAD]  = sat_bad;
        s[ST_SAT_GOOD] = sat_good;
        return s;
    endfunction

endpackage

// File: rtl/bsync_sat_counter.sv
// bsync_sat_counter
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   - clock
//   rst   - synchronous active-high reset
//   clr   - synchronous clear, takes priority over inc
//   inc   - advance by one unless already all-ones
//   count - current count (CNT_W bits)
//   sat   - 1 while count is all-ones
import ericsmi_bad_sync_pkg::*;

module bsync_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    assign sat = &count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/ericsmi_bad_synchronizer.sv
// ericsmi_bad_synchronizer
// Metastability demonstrator. The asynchronous input ui_in[0] is captured by a
// lone flop (bad path) and by a SYNC_STAGES-deep synchronizer (good path).
// The bad path is delayed so both paths line up in time; saturating counters
// then record rising edges seen on each path and cycles where they disagree.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   ena       - tile enable, gates counting
//   ui_in     - [0] async din, [1] count enable, [4:2] read select,
//               [6:5] reserved, [7] counter clear
//   uo_out    - registered read-back byte
//   uio_in    - unused
//   uio_out   - [0] bad-path flop, [1] good-path output, rest 0
//   uio_oe    - constant 8'h03
// Build option: define BADSYNC_SNAPSHOT_EN to latch the full counter while its
// low byte is selected, so a following high-byte read is coherent.
import ericsmi_bad_sync_pkg::*;

module ericsmi_bad_synchronizer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic din;
    assign din = ui_in[0];

    // bad_line[0] is the single sampling flop; the rest is a pure delay so that
    // its last tap carries din from the same cycle as the synchronizer output.
    logic [SYNC_STAGES-1:0] bad_line;
    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   q_bad_dd;
    logic                   sync_out_d;
    logic [1:0]             en_sync;
    logic [1:0]             clr_sync;

    logic q_bad;
    logic q_bad_d;
    logic sync_out;

    assign q_bad    = bad_line[0];
    assign q_bad_d  = bad_line[SYNC_STAGES-1];
    assign sync_out = sync_ff[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            bad_line   <= '0;
            sync_ff    <= '0;
            q_bad_dd   <= 1'b0;
            sync_out_d <= 1'b0;
            en_sync    <= '0;
            clr_sync   <= '0;
        end else begin
            bad_line   <= {bad_line[SYNC_STAGES-2:0], din};
            sync_ff    <= {sync_ff[SYNC_STAGES-2:0], din};
            q_bad_dd   <= q_bad_d;
            sync_out_d <= sync_out;
            en_sync    <= {en_sync[0], ui_in[1]};
            clr_sync   <= {clr_sync[0], ui_in[7]};
        end
    end

    // Read select is quasi-static and therefore used unsynchronized.
    sel_e sel;
    assign sel = sel_e'(ui_in[4:2]);

    logic cnt_en;
    logic clr;
    assign cnt_en = ena & en_sync[1];
    assign clr    = clr_sync[1];

    logic mis_inc;
    logic bad_inc;
    logic good_inc;
    assign mis_inc  = cnt_en & (q_bad_d ^ sync_out);
    assign bad_inc  = cnt_en & q_bad_d & ~q_bad_dd;
    assign good_inc = cnt_en & sync_out & ~sync_out_d;

    logic [CNT_W-1:0] mis_cnt;
    logic [CNT_W-1:0] bad_cnt;
    logic [CNT_W-1:0] good_cnt;
    logic             sat_mis;
    logic             sat_bad;
    logic             sat_good;

    bsync_sat_counter #(.CNT_W(CNT_W)) u_mis_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (mis_inc),
        .count (mis_cnt),
        .sat   (sat_mis)
    );

    bsync_sat_counter #(.CNT_W(CNT_W)) u_bad_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (bad_inc),
        .count (bad_cnt),
        .sat   (sat_bad)
    );

    bsync_sat_counter #(.CNT_W(CNT_W)) u_good_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (good_inc),
        .count (good_cnt),
        .sat   (sat_good)
    );

    // Zero-extend to a 16-bit read view so narrow builds read 0 in the upper bits.
    logic [15:0] mis_w;
    logic [15:0] bad_w;
    logic [15:0] good_w;
    assign mis_w  = 16'(mis_cnt);
    assign bad_w  = 16'(bad_cnt);
    assign good_w = 16'(good_cnt);

    logic [7:0] mis_hi;
    logic [7:0] bad_hi;
    logic [7:0] good_hi;

`ifdef BADSYNC_SNAPSHOT_EN
    logic [CNT_W-1:0] shadow;
    sel_e             shadow_src;
    logic [15:0]      shadow_w;
    assign shadow_w = 16'(shadow);

    // Capture the whole counter while its low byte is being read so the
    // subsequent high-byte read cannot tear across a carry.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow     <= '0;
            shadow_src <= SEL_MIS_LO;
        end else if (clr) begin
            shadow <= '0;
        end else begin
            case (sel)
                SEL_MIS_LO: begin
                    shadow     <= mis_cnt;
                    shadow_src <= SEL_MIS_LO;
                end
                SEL_BAD_LO: begin
                    shadow     <= bad_cnt;
                    shadow_src <= SEL_BAD_LO;
                end
                SEL_GOOD_LO: begin
                    shadow     <= good_cnt;
                    shadow_src <= SEL_GOOD_LO;
                end
                default: begin
                    shadow     <= shadow;
                    shadow_src <= shadow_src;
                end
            endcase
        end
    end

    assign mis_hi  = (shadow_src == SEL_MIS_LO)  ? shadow_w[15:8] : mis_w[15:8];
    assign bad_hi  = (shadow_src == SEL_BAD_LO)  ? shadow_w[15:8] : bad_w[15:8];
    assign good_hi = (shadow_src == SEL_GOOD_LO) ? shadow_w[15:8] : good_w[15:8];
`else
    assign mis_hi  = mis_w[15:8];
    assign bad_hi  = bad_w[15:8];
    assign good_hi = good_w[15:8];
`endif

    logic [7:0] rd_data;

    always_comb begin
        rd_data = ID_BYTE;
        case (sel)
            SEL_MIS_LO:  rd_data = mis_w[7:0];
            SEL_MIS_HI:  rd_data = mis_hi;
            SEL_BAD_LO:  rd_data = bad_w[7:0];
            SEL_BAD_HI:  rd_data = bad_hi;
            SEL_GOOD_LO: rd_data = good_w[7:0];
            SEL_GOOD_HI: rd_data = good_hi;
            SEL_STATUS:  rd_data = pack_status(sat_good, sat_bad, sat_mis, sync_out, q_bad_d);
            default:     rd_data = ID_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uo_out <= '0;
        end else begin
            uo_out <= rd_data;
        end
    end

    assign uio_out = {6'b0, sync_out, q_bad};
    assign uio_oe  = UIO_OE_VAL;

    logic unused_inputs;
    assign unused_inputs = ^{uio_in, ui_in[6:5]};

endmodule

// File: tb/tb_ericsmi_bad_synchronizer.sv
// Testbench for ericsmi_bad_synchronizer, built with an 8-bit counter so that
// saturation is reachable. The reference model keeps a per-cycle history of
// the sampled din and control inputs and derives every expected read-back byte
// from those histories with plain arithmetic.
module tb_ericsmi_bad_synchronizer;

    localparam int CNT_W = 8;
    localparam int S     = 2;
    localparam int MAXC  = (1 << CNT_W) - 1;
    localparam int HLEN  = 4096;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    always #5 clk = ~clk;

    ericsmi_bad_synchronizer #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (S)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         cyc = 0;
    bit         d_h [0:HLEN-1];
    bit         e_h [0:HLEN-1];
    bit         c_h [0:HLEN-1];
    int         mis_c = 0;
    int         bad_c = 0;
    int         good_c = 0;
    int         shadow_c = 0;
    int         shadow_src = 0;
    logic [7:0] exp_uo = 8'h00;
    logic [7:0] exp_uio = 8'h00;

    function automatic bit dh(int i);
        if (i < 0 || i >= HLEN) return 1'b0;
        return d_h[i];
    endfunction

    function automatic bit eh(int i);
        if (i < 0 || i >= HLEN) return 1'b0;
        return e_h[i];
    endfunction

    function automatic bit ch(int i);
        if (i < 0 || i >= HLEN) return 1'b0;
        return c_h[i];
    endfunction

    function automatic int sat_add(int v, bit inc);
        if (inc && v < MAXC) return v + 1;
        return v;
    endfunction

    // Cycle k: din seen at edge k reaches the aligned outputs S edges later.
    // A counter bumps at edge k when din went 0->1 between samples k-S-1 and
    // k-S, gated by ena now and the count-enable input sampled two edges ago.
    // Clear likewise acts two edges after it is sampled. In zero-delay
    // simulation both paths see identical samples, so MISMATCH never moves.
    always @(posedge clk) begin : model
        int         k;
        int         sel_i;
        int         hv;
        bit         clr_e;
        bit         en_e;
        bit         rise;
        logic [7:0] st;
        k = cyc;
        if (k < HLEN) begin
            d_h[k] = rst ? 1'b0 : ui_in[0];
            e_h[k] = rst ? 1'b0 : ui_in[1];
            c_h[k] = rst ? 1'b0 : ui_in[7];
        end
        exp_uio = {6'b0, dh(k - S + 1), dh(k)};
        if (rst) begin
            exp_uo     = 8'h00;
            mis_c      = 0;
            bad_c      = 0;
            good_c     = 0;
            shadow_c   = 0;
            shadow_src = 0;
        end else begin
            st    = 8'h00;
            st[0] = dh(k - S);
            st[1] = dh(k - S);
            st[2] = (mis_c == MAXC);
            st[3] = (bad_c == MAXC);
            st[4] = (good_c == MAXC);
            sel_i = int'(ui_in[4:2]);
            hv    = 0;
            case (sel_i)
                0: exp_uo = 8'(mis_c);
                1: begin
                    hv = mis_c;
`ifdef BADSYNC_SNAPSHOT_EN
                    if (shadow_src == 0) hv = shadow_c;
`endif
                    exp_uo = 8'(hv >> 8);
                end
                2: exp_uo = 8'(bad_c);
                3: begin
                    hv = bad_c;
`ifdef BADSYNC_SNAPSHOT_EN
                    if (shadow_src == 2) hv = shadow_c;
`endif
                    exp_uo = 8'(hv >> 8);
                end
                4: exp_uo = 8'(good_c);
                5: begin
                    hv = good_c;
`ifdef BADSYNC_SNAPSHOT_EN
                    if (shadow_src == 4) hv = shadow_c;
`endif
                    exp_uo = 8'(hv >> 8);
                end
                6: exp_uo = st;
                default: exp_uo = 8'hA5;
            endcase
            clr_e = ch(k - 2);
            en_e  = eh(k - 2) & ena;
            rise  = dh(k - S) & ~dh(k - S - 1);
            if (clr_e) begin
                mis_c    = 0;
                bad_c    = 0;
                good_c   = 0;
                shadow_c = 0;
            end else begin
                if (sel_i == 0) begin shadow_c = mis_c;  shadow_src = 0; end
                if (sel_i == 2) begin shadow_c = bad_c;  shadow_src = 2; end
                if (sel_i == 4) begin shadow_c = good_c; shadow_src = 4; end
                bad_c  = sat_add(bad_c, en_e & rise);
                good_c = sat_add(good_c, en_e & rise);
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("uo_out_model", uo_out, exp_uo);
            check("uio_out_model", uio_out, exp_uio);
        end
    endtask

    task automatic set_sel(input int s);
        ui_in[4:2] = 3'(s);
    endtask

    initial begin
        // Reset
        rst   = 1'b1;
        ui_in = 8'h00;
        step(2);
        rst = 1'b0;
        set_sel(7);
        step(1);
        check("id_byte", uo_out, 8'hA5);
        check("uio_oe", uio_oe, 8'h03);
        set_sel(0);
        step(1);
        check("mis_lo_after_reset", uo_out, 8'h00);

        // Static din: nothing counts
        ena      = 1'b1;
        ui_in[1] = 1'b1;
        ui_in[0] = 1'b0;
        step(100);
        for (int s = 0; s < 6; s++) begin
            set_sel(s);
            step(2);
            check("static_counter_byte", uo_out, 8'h00);
        end
        check("static_uio_out", uio_out, 8'h00);

        // Ten rising edges with random spacing
        for (int i = 0; i < 10; i++) begin
            ui_in[0] = 1'b1;
            step($urandom_range(1, 3));
            ui_in[0] = 1'b0;
            step($urandom_range(1, 3));
        end
        step(4);
        set_sel(2); step(2); check("bad_rise_10", uo_out, 8'd10);
        set_sel(4); step(2); check("good_rise_10", uo_out, 8'd10);
        set_sel(0); step(2); check("mismatch_0", uo_out, 8'd0);
        set_sel(3); step(2); check("bad_rise_hi_0", uo_out, 8'd0);

        // Status bits follow din two cycles late (adds an 11th rise)
        set_sel(6); step(2); check("status_idle", uo_out, 8'h00);
        ui_in[0] = 1'b1;
        step(2); check("status_lag_low", uo_out, 8'h00);
        step(1); check("status_high", uo_out, 8'h03);
        ui_in[0] = 1'b0;
        step(2); check("status_lag_high", uo_out, 8'h03);
        step(1); check("status_low", uo_out, 8'h00);
        step(4);

        // Gating: ena low freezes counters
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ui_in[0] = 1'b1;
            step(1);
            ui_in[0] = 1'b0;
            step(1);
        end
        step(4);
        ena = 1'b1;
        set_sel(2); step(2); check("bad_rise_held", uo_out, 8'd11);
        set_sel(4); step(2); check("good_rise_held", uo_out, 8'd11);

        // Saturation at 0xFF
        for (int i = 0; i < 300; i++) begin
            ui_in[0] = 1'b1;
            step(1);
            ui_in[0] = 1'b0;
            step(1);
        end
        step(4);
        set_sel(2); step(2); check("bad_rise_sat", uo_out, 8'hFF);
        set_sel(3); step(2); check("bad_rise_hi_narrow", uo_out, 8'h00);
        set_sel(4); step(2); check("good_rise_sat", uo_out, 8'hFF);
        set_sel(6); step(2); check("status_sat", uo_out, 8'h18);

        // Clear pulse: counters zero two sync stages plus one cycle later
        set_sel(2); step(2);
        ui_in[7] = 1'b1;
        step(1);
        ui_in[7] = 1'b0;
        step(2); check("bad_before_clear", uo_out, 8'hFF);
        step(1); check("bad_after_clear", uo_out, 8'h00);
        set_sel(6); step(2); check("status_after_clear", uo_out, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            ui_in[0]   = 1'($urandom_range(0, 1));
            ena        = ($urandom_range(0, 9) != 0);
            ui_in[1]   = ($urandom_range(0, 9) != 0);
            ui_in[4:2] = 3'($urandom_range(0, 7));
            ui_in[6:5] = 2'($urandom_range(0, 3));
            ui_in[7]   = ($urandom_range(0, 49) == 0);
            uio_in     = 8'($urandom_range(0, 255));
            step(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
